// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback arbiter and its MD result buffer.
package wb_arb_pkg;
  localparam int DEPTH_DEF        = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic [31:0] data;
  } entry_t;

  function automatic logic rd_hit(input entry_t e, input reg_addr_t rd);
    return e.valid && (e.rd == rd);
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of pending MD results with squash-by-destination and compaction.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         push,
  input  reg_addr_t                    push_rd,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  input  logic                         squash_en,
  input  reg_addr_t                    squash_rd,
  input  reg_addr_t                    cmp_a,
  input  reg_addr_t                    cmp_b,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DEPTH-1:0]             match_a,
  output logic [DEPTH-1:0]             match_b
);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] keep;
  int              pos [DEPTH];
  int              n_kept;

  always_comb begin
    n_kept = 0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = rd_hit(ent_q[i], cmp_a);
      match_b[i] = rd_hit(ent_q[i], cmp_b);
      // An entry popped and squashed in the same cycle leaves only once.
      keep[i]    = ent_q[i].valid && !(squash_en && rd_hit(ent_q[i], squash_rd))
                   && !(pop && (i == 0));
      pos[i]     = n_kept;
      if (keep[i]) n_kept = n_kept + 1;
    end

    for (int k = 0; k < DEPTH; k++) begin
      ent_d[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && (pos[i] == k)) ent_d[k] = ent_q[i];
      end
      if (push && (n_kept == k)) ent_d[k] = '{valid: 1'b1, rd: push_rd, data: push_data};
    end

    count_d = (push && (n_kept < DEPTH)) ? CW'(n_kept + 1) : CW'(n_kept);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

  assign head  = ent_q[0];
  assign count = count_q;
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter between the pipeline writeback stage and
// buffered multiply/divide results, with starvation relief and WAW squash.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int DEPTH        = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic        hazard_rs,
  output logic        hazard_rt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  entry_t           head;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] match_rs, match_rt;

  logic             md_acc, starve_grant, squash_en, md_squash, head_sq;
  logic             pop, push, bypass;
  logic             grant_vld;
  reg_addr_t        grant_rd;
  logic [31:0]      grant_data;

  logic [SW-1:0]    starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  reg_addr_t        rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (push),
    .push_rd   (md_rd),
    .push_data (md_data),
    .pop       (pop),
    .squash_en (squash_en),
    .squash_rd (pipe_rd),
    .cmp_a     (chk_rs),
    .cmp_b     (chk_rt),
    .head      (head),
    .count     (count),
    .match_a   (match_rs),
    .match_b   (match_rt)
  );

  always_comb begin
    md_ready     = (count < CW'(DEPTH));
    md_acc       = md_valid && md_ready;
    starve_grant = head.valid && (starve_q == SW'(STARVE_LIMIT));
    pipe_stall   = starve_grant;
    // A stalled pipeline write is not performed, so it cannot squash anything.
    squash_en    = pipe_we && !starve_grant && (pipe_rd != 5'd0);
    md_squash    = squash_en && (md_rd == pipe_rd);
    head_sq      = squash_en && rd_hit(head, pipe_rd);

    pop        = 1'b0;
    bypass     = 1'b0;
    grant_vld  = 1'b0;
    grant_rd   = '0;
    grant_data = '0;
    if (starve_grant) begin
      pop = 1'b1; grant_vld = 1'b1; grant_rd = head.rd; grant_data = head.data;
    end else if (pipe_we) begin
      grant_vld = 1'b1; grant_rd = pipe_rd; grant_data = pipe_data;
    end else if (head.valid) begin
      pop = 1'b1; grant_vld = 1'b1; grant_rd = head.rd; grant_data = head.data;
    end else if (md_acc) begin
      bypass = 1'b1; grant_vld = 1'b1; grant_rd = md_rd; grant_data = md_data;
    end

    // Results to r0 or overwritten this cycle by the pipeline are accepted and dropped.
    push = md_acc && !bypass && (md_rd != 5'd0) && !md_squash;

    if (!head.valid || pop || head_sq) starve_d = '0;
    else if (pipe_we)                  starve_d = starve_q + SW'(1);
    else                               starve_d = starve_q;

    rf_we_d   = grant_vld && (grant_rd != 5'd0);
    rf_addr_d = grant_vld ? grant_rd : rf_addr_q;
    rf_data_d = grant_vld ? grant_data : rf_data_q;

    hazard_rs = (chk_rs != 5'd0) && (|match_rs);
    hazard_rt = (chk_rt != 5'd0) && (|match_rt);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        nrst;
  logic        pipe_we, md_valid;
  logic [4:0]  pipe_rd, md_rd, chk_rs, chk_rt;
  logic [31:0] pipe_data, md_data;
  logic        md_ready, pipe_stall, rf_we, hazard_rs, hazard_rt;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(4), .DEPTH(2)) dut (
    .clk(clk), .nrst(nrst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .md_ready(md_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .chk_rs(chk_rs), .chk_rt(chk_rt),
    .hazard_rs(hazard_rs), .hazard_rt(hazard_rt)
  );

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rdy;
    logic        stall;
    logic        hrs;
    logic        hrt;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic rdy, input logic stall, input logic hrs, input logic hrt,
                              input logic we, input logic [4:0] addr, input logic [31:0] data);
    vec_t v;
    v.pwe = pwe; v.prd = prd; v.pdat = pdat; v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.rs = rs; v.rt = rt; v.rdy = rdy; v.stall = stall; v.hrs = hrs; v.hrt = hrt;
    v.we = we; v.addr = addr; v.data = data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive, check combinational outputs, then check the registered write.
  task automatic apply(input vec_t v, input string tag);
    pipe_we = v.pwe; pipe_rd = v.prd; pipe_data = v.pdat;
    md_valid = v.mv; md_rd = v.mrd; md_data = v.mdat;
    chk_rs = v.rs; chk_rt = v.rt;
    #1;
    chk({tag, " md_ready"},   32'(md_ready),   32'(v.rdy));
    chk({tag, " pipe_stall"}, 32'(pipe_stall), 32'(v.stall));
    chk({tag, " hazard_rs"},  32'(hazard_rs),  32'(v.hrs));
    chk({tag, " hazard_rt"},  32'(hazard_rt),  32'(v.hrt));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " rf_we"}, 32'(rf_we), 32'(v.we));
    if (v.we) begin
      chk({tag, " rf_addr"}, 32'(rf_addr), 32'(v.addr));
      chk({tag, " rf_data"}, rf_data, v.data);
    end
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = mk(1, 5, 32'h1234, 0, 0, 0,          0, 0,   1, 0, 0, 0,  1, 5,  32'h1234);
    tbl[1]  = mk(0, 0, 0,        1, 7, 32'hA5A5,   0, 0,   1, 0, 0, 0,  1, 7,  32'hA5A5);
    tbl[2]  = mk(0, 0, 0,        0, 0, 0,          7, 7,   1, 0, 0, 0,  0, 0,  0);
    tbl[3]  = mk(0, 0, 0,        1, 0, 32'hDEAD,   0, 0,   1, 0, 0, 0,  0, 0,  0);
    tbl[4]  = mk(1, 1, 32'h11,   1, 0, 32'hBEEF,   0, 0,   1, 0, 0, 0,  1, 1,  32'h11);
    tbl[5]  = mk(0, 0, 0,        0, 0, 0,          0, 0,   1, 0, 0, 0,  0, 0,  0);
    tbl[6]  = mk(1, 2, 32'h22,   1, 9, 32'h99,     0, 0,   1, 0, 0, 0,  1, 2,  32'h22);
    tbl[7]  = mk(1, 9, 32'h55,   0, 0, 0,          9, 0,   1, 0, 1, 0,  1, 9,  32'h55);
    tbl[8]  = mk(0, 0, 0,        0, 0, 0,          9, 9,   1, 0, 0, 0,  0, 0,  0);
    tbl[9]  = mk(1, 3, 32'h33,   1, 10, 32'hAAAA,  0, 0,   1, 0, 0, 0,  1, 3,  32'h33);
    tbl[10] = mk(1, 4, 32'h44,   1, 11, 32'hBBBB,  10, 11, 1, 0, 1, 0,  1, 4,  32'h44);
    tbl[11] = mk(0, 0, 0,        0, 0, 0,          10, 11, 0, 0, 1, 1,  1, 10, 32'hAAAA);
    tbl[12] = mk(0, 0, 0,        1, 12, 32'hC0C0,  0, 11,  1, 0, 0, 1,  1, 11, 32'hBBBB);
    tbl[13] = mk(1, 12, 32'h77,  1, 13, 32'h1313,  12, 0,  1, 0, 1, 0,  1, 12, 32'h77);
    tbl[14] = mk(0, 0, 0,        0, 0, 0,          12, 13, 1, 0, 0, 1,  1, 13, 32'h1313);
    tbl[15] = mk(1, 14, 32'hE,   1, 14, 32'hF00D,  0, 0,   1, 0, 0, 0,  1, 14, 32'hE);
    tbl[16] = mk(0, 0, 0,        0, 0, 0,          14, 0,  1, 0, 0, 0,  0, 0,  0);

    nrst = 1'b0;
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0; chk_rs = 0; chk_rt = 0;
    repeat (2) @(negedge clk);
    chk("reset rf_we",      32'(rf_we),      0);
    chk("reset rf_addr",    32'(rf_addr),    0);
    chk("reset rf_data",    rf_data,         0);
    chk("reset md_ready",   32'(md_ready),   1);
    chk("reset pipe_stall", 32'(pipe_stall), 0);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Starvation: pipeline writes r20 every cycle while r3 then r4 wait in the buffer.
    for (int c = 0; c <= 10; c++) begin
      vec_t v;
      logic stall_e;
      stall_e = (c == 5) || (c == 10);
      v = mk(1, 20, 32'h100 + 32'(c),
             (c < 2), (c == 0) ? 5'd3 : 5'd4, (c == 0) ? 32'hA3 : 32'hA4,
             3, 4,
             !(c >= 2 && c <= 5), stall_e, (c >= 1 && c <= 5), (c >= 2),
             1, (c == 5) ? 5'd3 : (c == 10) ? 5'd4 : 5'd20,
             (c == 5) ? 32'hA3 : (c == 10) ? 32'hA4 : 32'h100 + 32'(c));
      apply(v, $sformatf("starve%0d", c));
    end
    apply(mk(0, 0, 0, 0, 0, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0), "starve_end");

    // Reset with two results pending: nothing from them may ever be written.
    apply(mk(1, 20, 32'h200, 1, 21, 32'h2121, 21, 22, 1, 0, 0, 0, 1, 20, 32'h200), "rst_fill0");
    apply(mk(1, 20, 32'h201, 1, 22, 32'h2222, 21, 22, 1, 0, 1, 0, 1, 20, 32'h201), "rst_fill1");
    pipe_we = 0; md_valid = 0;
    #2 nrst = 1'b0;
    #1;
    chk("midrst rf_we",      32'(rf_we),      0);
    chk("midrst rf_addr",    32'(rf_addr),    0);
    chk("midrst rf_data",    rf_data,         0);
    chk("midrst md_ready",   32'(md_ready),   1);
    chk("midrst pipe_stall", 32'(pipe_stall), 0);
    chk("midrst hazard_rs",  32'(hazard_rs),  0);
    chk("midrst hazard_rt",  32'(hazard_rt),  0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 21, 22, 1, 0, 0, 0, 0, 0, 0), $sformatf("post_rst%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive cycles a buffered MD result may lose arbitration.
REQ-002 Parameter: DEPTH, default 2, MD result buffer entries.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports clk and nrst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 nrst  in  1  asynchronous active-low reset.
REQ-006 pipe_we  in  1  pipeline writeback-stage write request.
REQ-007 pipe_rd  in  5  pipeline destination register.
REQ-008 pipe_data  in  32  pipeline write data (selected ALU/memory result).
REQ-009 md_valid  in  1  multiply/divide unit result valid.
REQ-010 md_rd  in  5  MD destination register.
REQ-011 md_data  in  32  MD result.
REQ-012 md_ready  out  1  MD result accepted this cycle when md_valid also high.
REQ-013 pipe_stall  out  1  pipeline SHALL hold its writeback stage this cycle.
REQ-014 rf_we, rf_addr[4:0], rf_data[31:0]  out  register-file write port, registered.
REQ-015 chk_rs, chk_rt  in  5 each  decode-stage source registers.
REQ-016 hazard_rs, hazard_rt  out  1 each  source matches a pending MD destination.

Function
REQ-017 md_ready SHALL equal (count < DEPTH), count being the registered buffer occupancy; no same-cycle pass-through when full.
REQ-018 Grant priority per cycle: starvation grant > pipeline > buffer head > bypass of incoming MD result.
REQ-019 Bypass: buffer empty, pipe_we low, md_valid high -> MD result written directly; not enqueued.
REQ-020 Otherwise an accepted MD result SHALL be enqueued at the tail; enqueue and dequeue in the same cycle SHALL be legal.
REQ-021 Granted write SHALL appear on rf_we/rf_addr/rf_data one cycle after the grant cycle (latency 1).
REQ-022 Writes with destination 0 SHALL never assert rf_we; MD results to r0 are accepted and discarded.
REQ-023 starve counter SHALL increment each cycle a valid head entry is blocked by pipe_we; it SHALL clear on head dequeue or squash.
REQ-024 pipe_stall SHALL assert combinationally when the counter equals STARVE_LIMIT and the head is valid; that cycle the head is granted and the pipeline write is not performed.
REQ-025 WAW squash: pipe_we with pipe_rd != 0 matching a valid buffered entry SHALL invalidate that entry; a same-cycle incoming md_rd match SHALL be accepted and discarded.
REQ-026 Squashed entries SHALL be compacted out; count decrements accordingly; simultaneous squash and dequeue of one entry counts once.
REQ-027 hazard_x SHALL be high iff chk_x != 0 and matches md_rd of a valid buffered entry (combinational).
REQ-028 The buffer SHALL preserve FIFO order of MD results.

Reset
REQ-029 nrst low SHALL immediately clear buffer valid bits, count, starve counter, rf_we, rf_addr, rf_data to 0; md_ready is 1, pipe_stall and hazard outputs 0 while in reset.
REQ-030 Reset mid-operation SHALL discard pending MD results without any register-file write.

Structure
REQ-031 Package wb_arb_pkg SHALL hold DEPTH and STARVE_LIMIT defaults, reg-address typedef, and the buffer-entry struct (valid, rd, data).
REQ-032 Buffer SHALL be a sub-module wb_fifo (DEPTH entries, push/pop/squash-by-rd, per-entry rd match outputs).

Verification
REQ-033 Pipeline write r5=0x1234 alone -> next cycle rf_we=1, rf_addr=5, rf_data=0x1234.
REQ-034 md_valid r7=0xA5A5 with pipe_we low, buffer empty -> bypass, rf_addr=7 next cycle, count stays 0.
REQ-035 pipe_we held high, two MD results r3, r4 -> md_ready falls at count=2; hazard_rs high for chk_rs=3; pipe_stall pulses after 4 blocked cycles, r3 written first, then r4.
REQ-036 Buffered r9, then pipe_we r9=0x55 -> entry squashed, final r9=0x55, hazard for chk_rs=9 clears.
REQ-037 MD result to r0 -> md_ready=1, rf_we never asserted.
REQ-038 nrst asserted with 2 entries pending -> outputs reset immediately, no subsequent rf_we for those entries.
